// File: rtl/nmu_cfg_pkg.sv
// Shared types for the NMU configuration controllers.
package nmu_cfg_pkg;

    localparam int SA_MAC_SIZE = 48;

    typedef logic [SA_MAC_SIZE-1:0] mac_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        APPLY = 2'd2
    } cam_cfg_state_t;

    // Reset contents of a CAM entry: zero address with must_match set, so
    // nothing routes until software has installed a real table.
    localparam mac_t MAC_RESET = '0;
    localparam logic MM_RESET  = 1'b1;

endpackage

// File: rtl/axis_pkt_boundary.sv
// Tracks whether an AXI-Stream link is inside a packet and flags the
// cycles after which the link is between packets.
module axis_pkt_boundary (
    input  logic aclk,
    input  logic aresetn,
    input  logic beat,
    input  logic last,
    output logic in_pkt,
    output logic pkt_idle_next
);

    logic in_pkt_q;
    logic in_pkt_d;

    // A non-last beat opens a packet, a last beat closes it.
    always_comb begin
        in_pkt_d = in_pkt_q;
        if (beat) begin
            in_pkt_d = ~last;
        end
    end

    // Packet-open flag register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_pkt_q <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
        end
    end

    assign in_pkt        = in_pkt_q;
    // True when the next cycle starts outside any packet.
    assign pkt_idle_next = (~in_pkt_q & ~beat) | (beat & last);

endmodule

// File: rtl/mac_cam_cfg_ctrl.sv
// MAC routing CAM owner: software fills a shadow table, then a commit swaps
// it into the active table at a packet boundary with a one-cycle stream stall.
//
// state | meaning
// IDLE  | shadow writable, commit accepted
// WAIT  | commit pending, shadow frozen, waiting for a packet boundary
// APPLY | stream stalled for one cycle; shadow copied to active on exit
module mac_cam_cfg_ctrl
    import nmu_cfg_pkg::*;
#(
    parameter int AXIS_ID_WIDTH = 4,
    parameter int MAC_WIDTH     = SA_MAC_SIZE,
    parameter int GEN_WIDTH     = 8,
    localparam int NUM_AXIS_ID  = 2**AXIS_ID_WIDTH
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,

    input  logic                                  cfg_wr_valid,
    output logic                                  cfg_wr_ready,
    input  logic [AXIS_ID_WIDTH-1:0]              cfg_wr_idx,
    input  logic [MAC_WIDTH-1:0]                  cfg_wr_mac,
    input  logic                                  cfg_wr_must_match,

    input  logic                                  cfg_commit_valid,
    output logic                                  cfg_commit_ready,
    output logic                                  cfg_commit_done,
    output logic [GEN_WIDTH-1:0]                  cfg_generation,

    input  logic                                  cfg_rd_valid,
    input  logic [AXIS_ID_WIDTH-1:0]              cfg_rd_idx,
    output logic                                  cfg_rd_data_valid,
    output logic [MAC_WIDTH-1:0]                  cfg_rd_mac,
    output logic                                  cfg_rd_must_match,

    input  logic                                  axis_tvalid,
    input  logic                                  axis_tlast,
    input  logic                                  axis_tready_in,
    output logic                                  axis_tready_out,

    output logic [NUM_AXIS_ID-1:0][MAC_WIDTH-1:0] mac_addresses,
    output logic [NUM_AXIS_ID-1:0]                mac_cam_must_match
);

    cam_cfg_state_t state_q, state_d;

    logic [NUM_AXIS_ID-1:0][MAC_WIDTH-1:0] shadow_mac_q, shadow_mac_d;
    logic [NUM_AXIS_ID-1:0]                shadow_mm_q,  shadow_mm_d;
    logic [NUM_AXIS_ID-1:0][MAC_WIDTH-1:0] active_mac_q, active_mac_d;
    logic [NUM_AXIS_ID-1:0]                active_mm_q,  active_mm_d;

    logic [GEN_WIDTH-1:0]  gen_q, gen_d;
    logic                  done_q, done_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [MAC_WIDTH-1:0]  rd_mac_q, rd_mac_d;
    logic                  rd_mm_q, rd_mm_d;

    logic apply_now;
    logic beat;
    logic in_pkt;
    logic pkt_idle_next;
    logic wr_fire;

    assign beat    = axis_tvalid & axis_tready_out;
    assign wr_fire = cfg_wr_valid & cfg_wr_ready;

    axis_pkt_boundary u_pkt_boundary (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .beat          (beat),
        .last          (axis_tlast),
        .in_pkt        (in_pkt),
        .pkt_idle_next (pkt_idle_next)
    );

    // Commit sequencing: an idle link goes straight to APPLY, otherwise the
    // commit waits for the cycle that ends the current packet.
    always_comb begin
        state_d          = state_q;
        cfg_wr_ready     = 1'b0;
        cfg_commit_ready = 1'b0;
        axis_tready_out  = axis_tready_in;
        apply_now        = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_wr_ready     = 1'b1;
                cfg_commit_ready = 1'b1;
                if (cfg_commit_valid) begin
                    state_d = pkt_idle_next ? APPLY : WAIT;
                end
            end
            WAIT: begin
                if (pkt_idle_next) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                axis_tready_out = 1'b0;
                apply_now       = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shadow table: software writes land here; a write accepted together
    // with a commit is part of that commit because the copy happens later.
    always_comb begin
        shadow_mac_d = shadow_mac_q;
        shadow_mm_d  = shadow_mm_q;
        if (wr_fire) begin
            shadow_mac_d[cfg_wr_idx] = cfg_wr_mac;
            shadow_mm_d[cfg_wr_idx]  = cfg_wr_must_match;
        end
    end

    // Active table, generation counter and done pulse all change on the
    // APPLY exit edge only.
    always_comb begin
        active_mac_d = active_mac_q;
        active_mm_d  = active_mm_q;
        gen_d        = gen_q;
        done_d       = apply_now;
        if (apply_now) begin
            active_mac_d = shadow_mac_q;
            active_mm_d  = shadow_mm_q;
            gen_d        = gen_q + {{(GEN_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Readback samples the active table before any same-edge update, so a
    // read during APPLY returns the outgoing entry.
    always_comb begin
        rd_valid_d = cfg_rd_valid;
        rd_mac_d   = rd_mac_q;
        rd_mm_d    = rd_mm_q;
        if (cfg_rd_valid) begin
            rd_mac_d = active_mac_q[cfg_rd_idx];
            rd_mm_d  = active_mm_q[cfg_rd_idx];
        end
    end

    // State and table registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            shadow_mac_q <= {NUM_AXIS_ID{MAC_RESET[MAC_WIDTH-1:0]}};
            shadow_mm_q  <= {NUM_AXIS_ID{MM_RESET}};
            active_mac_q <= {NUM_AXIS_ID{MAC_RESET[MAC_WIDTH-1:0]}};
            active_mm_q  <= {NUM_AXIS_ID{MM_RESET}};
            gen_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_mac_q <= shadow_mac_d;
            shadow_mm_q  <= shadow_mm_d;
            active_mac_q <= active_mac_d;
            active_mm_q  <= active_mm_d;
            gen_q        <= gen_d;
            done_q       <= done_d;
        end
    end

    // Readback registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_valid_q <= 1'b0;
            rd_mac_q   <= '0;
            rd_mm_q    <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_mac_q   <= rd_mac_d;
            rd_mm_q    <= rd_mm_d;
        end
    end

    assign mac_addresses      = active_mac_q;
    assign mac_cam_must_match = active_mm_q;
    assign cfg_commit_done    = done_q;
    assign cfg_generation     = gen_q;
    assign cfg_rd_data_valid  = rd_valid_q;
    assign cfg_rd_mac         = rd_mac_q;
    assign cfg_rd_must_match  = rd_mm_q;

endmodule
